// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - multi-cycle CPU control FSM; optional jal support under macro MCC_JAL_EN
module multi_cycle_control (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] Op,
   input  logic       Zero,
   output logic [2:0] State,
   output logic       PCWre,
   output logic       IRWre,
   output logic       InsMemRW,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       ExtSel,
   output logic       RegWre,
   output logic [1:0] RegDst,
   output logic       WrRegDSrc,
   output logic       DBDataSrc,
   output logic       mRD,
   output logic       mWR,
   output logic [1:0] PCSrc
);

   typedef enum logic [2:0] {
      S_IF  = 3'b000,
      S_ID  = 3'b001,
      S_EXE = 3'b010,
      S_WB  = 3'b011,
      S_BR  = 3'b100,
      S_MA  = 3'b101,
      S_MEM = 3'b110,
      S_MWB = 3'b111
   } state_t;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b000001;
   localparam logic [5:0] OP_SUB  = 6'b000010;
   localparam logic [5:0] OP_ORI  = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_OR   = 6'b010010;
   localparam logic [5:0] OP_SLL  = 6'b011000;
   localparam logic [5:0] OP_SLTI = 6'b011011;
   localparam logic [5:0] OP_SW   = 6'b100110;
   localparam logic [5:0] OP_LW   = 6'b100111;
   localparam logic [5:0] OP_BEQ  = 6'b110000;
   localparam logic [5:0] OP_BNE  = 6'b110001;
   localparam logic [5:0] OP_J    = 6'b111000;
   localparam logic [5:0] OP_JAL  = 6'b111010;
   localparam logic [5:0] OP_HALT = 6'b111111;

   state_t state_q;
   state_t state_d;

   logic       is_alu;
   logic       is_branch;
   logic       is_sw;
   logic       is_lw;
   logic       is_jump;
   logic       is_jal;
   logic       is_halt;
   logic       is_unknown;
   logic       br_taken;
   logic [2:0] alu_op_dec;
   logic       rd_dst;

   // Opcode classification and the state-independent datapath decodes
   always_comb begin
      is_alu     = 1'b0;
      alu_op_dec = 3'b000;
      rd_dst     = 1'b0;
      unique case (Op)
         OP_ADD:  begin is_alu = 1'b1; alu_op_dec = 3'b000; rd_dst = 1'b1; end
         OP_ADDI: begin is_alu = 1'b1; alu_op_dec = 3'b000; end
         OP_SUB:  begin is_alu = 1'b1; alu_op_dec = 3'b001; rd_dst = 1'b1; end
         OP_ORI:  begin is_alu = 1'b1; alu_op_dec = 3'b011; end
         OP_AND:  begin is_alu = 1'b1; alu_op_dec = 3'b100; rd_dst = 1'b1; end
         OP_OR:   begin is_alu = 1'b1; alu_op_dec = 3'b011; rd_dst = 1'b1; end
         OP_SLL:  begin is_alu = 1'b1; alu_op_dec = 3'b010; rd_dst = 1'b1; end
         OP_SLTI: begin is_alu = 1'b1; alu_op_dec = 3'b110; end
         OP_BEQ:  alu_op_dec = 3'b001;
         OP_BNE:  alu_op_dec = 3'b001;
         default: alu_op_dec = 3'b000;
      endcase
      is_branch = (Op == OP_BEQ) || (Op == OP_BNE);
      is_sw     = (Op == OP_SW);
      is_lw     = (Op == OP_LW);
      is_jump   = (Op == OP_J);
      is_halt   = (Op == OP_HALT);
`ifdef MCC_JAL_EN
      is_jal    = (Op == OP_JAL);
`else
      // Without jal support 111010 falls through to the unknown-opcode path
      is_jal    = 1'b0;
`endif
      is_unknown = !(is_alu || is_branch || is_sw || is_lw || is_jump || is_jal || is_halt);
      // Zero only matters to the branch decision, which is consumed in BR alone
      br_taken  = ((Op == OP_BEQ) && Zero) || ((Op == OP_BNE) && !Zero);
   end

   // State register; Reset parks the machine in IF immediately
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IF;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state selection
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IF:  state_d = S_ID;
         S_ID: begin
            if (is_alu)              state_d = S_EXE;
            else if (is_branch)      state_d = S_BR;
            else if (is_sw || is_lw) state_d = S_MA;
            else if (is_halt)        state_d = S_ID;
            else                     state_d = S_IF;
         end
         S_EXE: state_d = S_WB;
         S_WB:  state_d = S_IF;
         S_BR:  state_d = S_IF;
         S_MA:  state_d = S_MEM;
         S_MEM: state_d = is_lw ? S_MWB : S_IF;
         S_MWB: state_d = S_IF;
         default: state_d = S_IF;
      endcase
   end

   // Control outputs from current state, opcode and Zero; write strobes masked during Reset
   always_comb begin
      State     = state_q;
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      InsMemRW  = 1'b1;
      ALUSrcA   = (Op == OP_SLL);
      ALUSrcB   = (Op == OP_ADDI) || (Op == OP_ORI) || (Op == OP_SLTI) || is_sw || is_lw;
      ALUOp     = alu_op_dec;
      ExtSel    = (Op != OP_ORI);
      RegWre    = 1'b0;
      RegDst    = rd_dst ? 2'b10 : 2'b01;
      WrRegDSrc = 1'b1;
      DBDataSrc = 1'b0;
      mRD       = 1'b0;
      mWR       = 1'b0;
      PCSrc     = 2'b00;
      unique case (state_q)
         S_IF: IRWre = 1'b1;
         S_ID: begin
            if (is_jump || is_unknown) PCWre = 1'b1;
            if (is_jump) PCSrc = 2'b10;
            if (is_jal) begin
               PCWre     = 1'b1;
               PCSrc     = 2'b10;
               RegWre    = 1'b1;
               RegDst    = 2'b00;
               WrRegDSrc = 1'b0;
            end
         end
         S_EXE: ;
         S_WB: begin
            PCWre  = 1'b1;
            RegWre = 1'b1;
         end
         S_BR: begin
            PCWre = 1'b1;
            if (br_taken) PCSrc = 2'b01;
         end
         S_MA: ;
         S_MEM: begin
            if (is_sw) begin
               mWR   = 1'b1;
               PCWre = 1'b1;
            end else if (is_lw) begin
               mRD   = 1'b1;
            end
         end
         S_MWB: begin
            PCWre     = 1'b1;
            RegWre    = 1'b1;
            DBDataSrc = 1'b1;
         end
         default: ;
      endcase
      if (Reset) begin
         PCWre  = 1'b0;
         IRWre  = 1'b0;
         RegWre = 1'b0;
         mRD    = 1'b0;
         mWR    = 1'b0;
      end
   end

endmodule
